// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the packed-BCD counter.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] i_nib);
        return (i_nib <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with increment/decrement and terminal-count flags.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_CLR,
    input  logic             i_LOAD,
    input  logic [BCD_W-1:0] i_LOAD_VAL,
    input  logic             i_EN,
    input  logic             i_UP,
    output logic [BCD_W-1:0] o_DIGIT,
    output logic             o_TERM_UP,
    output logic             o_TERM_DN
);

    logic [BCD_W-1:0] r_digit;
    logic [BCD_W-1:0] w_next;

    assign o_TERM_UP = (r_digit == BCD_MAX);
    assign o_TERM_DN = (r_digit == '0);
    assign o_DIGIT   = r_digit;

    always_comb begin
        w_next = r_digit;
        if (i_UP) begin
            w_next = o_TERM_UP ? '0 : r_digit + 1'b1;
        end else begin
            w_next = o_TERM_DN ? BCD_MAX : r_digit - 1'b1;
        end
    end

    // i_LOAD is only asserted here once the whole load word has been validated
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_digit <= '0;
        end else if (i_CLR) begin
            r_digit <= '0;
        end else if (i_LOAD) begin
            r_digit <= i_LOAD_VAL;
        end else if (i_EN) begin
            r_digit <= w_next;
        end
    end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with load, clear and wrap/saturate limits.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit WRAP       = 1'b1
)(
    input  logic                        i_CLK,
    input  logic                        i_RST,
    input  logic                        i_CLK_EN,
    input  logic                        i_UP,
    input  logic                        i_CLR,
    input  logic                        i_LOAD,
    input  logic [BCD_W*NUM_DIGITS-1:0] i_LOAD_VAL,
    output logic [BCD_W*NUM_DIGITS-1:0] o_COUNT,
    output logic                        o_CARRY,
    output logic                        o_AT_MAX,
    output logic                        o_AT_MIN,
    output logic                        o_LOAD_ERR
);

    logic [NUM_DIGITS-1:0] w_term_up;
    logic [NUM_DIGITS-1:0] w_term_dn;
    logic [NUM_DIGITS-1:0] w_nib_ok;
    logic [NUM_DIGITS:0]   w_en;
    logic                  w_at_lim;
    logic                  w_step;
    logic                  w_load_ok;
    logic                  w_load_acc;
    logic                  r_carry;
    logic                  r_load_err;

    assign o_AT_MAX = &w_term_up;
    assign o_AT_MIN = &w_term_dn;

    assign w_at_lim   = i_UP ? o_AT_MAX : o_AT_MIN;
    assign w_step     = i_CLK_EN & ~i_CLR & ~i_LOAD;
    assign w_load_ok  = &w_nib_ok;
    assign w_load_acc = i_LOAD & w_load_ok;

    // Saturating mode kills the whole chain at the limit
    assign w_en[0] = w_step & ~(w_at_lim & ~WRAP);

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            assign w_nib_ok[k] = bcd_valid(i_LOAD_VAL[k*BCD_W +: BCD_W]);
            assign w_en[k+1]   = w_en[k]
                               & (i_UP ? w_term_up[k] : w_term_dn[k]);

            bcd_digit_cell u_cell (
                .i_CLK      (i_CLK),
                .i_RST      (i_RST),
                .i_CLR      (i_CLR),
                .i_LOAD     (w_load_acc),
                .i_LOAD_VAL (i_LOAD_VAL[k*BCD_W +: BCD_W]),
                .i_EN       (w_en[k]),
                .i_UP       (i_UP),
                .o_DIGIT    (o_COUNT[k*BCD_W +: BCD_W]),
                .o_TERM_UP  (w_term_up[k]),
                .o_TERM_DN  (w_term_dn[k])
            );
        end
    endgenerate

    // Enable rippling out of the top digit is exactly a wrap event
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_carry    <= w_en[NUM_DIGITS];
            r_load_err <= i_LOAD & ~i_CLR & ~w_load_ok;
        end
    end

    assign o_CARRY    = r_carry;
    assign o_LOAD_ERR = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench: 4-digit wrap, 2-digit saturate and 1-digit wrap counters.
module tb_bcd_updown_counter_n;

    typedef struct packed {
        logic        r;
        logic        c;
        logic        l;
        logic [15:0] v;
        logic        e;
        logic        u;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic [15:0] lv = '0;

    logic [15:0] cnt_a;
    logic [7:0]  cnt_b;
    logic [3:0]  cnt_c;
    logic        cy_a, cy_b, cy_c;
    logic        mx_a, mx_b, mx_c;
    logic        mn_a, mn_b, mn_c;
    logic        er_a, er_b, er_c;
    logic [59:0] act;

    logic [59:0] sb[$];
    logic [15:0] mcnt[3];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_n #(.NUM_DIGITS(4), .WRAP(1'b1)) u_a (
        .i_CLK(clk), .i_RST(rst), .i_CLK_EN(en), .i_UP(up),
        .i_CLR(clr), .i_LOAD(load), .i_LOAD_VAL(lv),
        .o_COUNT(cnt_a), .o_CARRY(cy_a), .o_AT_MAX(mx_a),
        .o_AT_MIN(mn_a), .o_LOAD_ERR(er_a)
    );

    bcd_updown_counter_n #(.NUM_DIGITS(2), .WRAP(1'b0)) u_b (
        .i_CLK(clk), .i_RST(rst), .i_CLK_EN(en), .i_UP(up),
        .i_CLR(clr), .i_LOAD(load), .i_LOAD_VAL(lv[7:0]),
        .o_COUNT(cnt_b), .o_CARRY(cy_b), .o_AT_MAX(mx_b),
        .o_AT_MIN(mn_b), .o_LOAD_ERR(er_b)
    );

    bcd_updown_counter_n #(.NUM_DIGITS(1), .WRAP(1'b1)) u_c (
        .i_CLK(clk), .i_RST(rst), .i_CLK_EN(en), .i_UP(up),
        .i_CLR(clr), .i_LOAD(load), .i_LOAD_VAL(lv[3:0]),
        .o_COUNT(cnt_c), .o_CARRY(cy_c), .o_AT_MAX(mx_c),
        .o_AT_MIN(mn_c), .o_LOAD_ERR(er_c)
    );

    assign act = {12'h0, cnt_c, cy_c, er_c, mx_c, mn_c,
                  8'h0, cnt_b, cy_b, er_b, mx_b, mn_b,
                  cnt_a, cy_a, er_a, mx_a, mn_a};

    function automatic stim_t st(input logic r, c, l,
                                 input logic [15:0] v,
                                 input logic e, u);
        stim_t s;
        s.r = r; s.c = c; s.l = l; s.v = v; s.e = e; s.u = u;
        return s;
    endfunction

    // Decimal-integer reference: {count, carry, load_err, at_max, at_min}
    function automatic logic [19:0] mstep(input int nd, input bit wr,
                                          input logic [15:0] cur,
                                          input stim_t s);
        int val, mx, nv, tmp;
        logic cy, er, ok;
        logic [15:0] o;
        val = 0; mx = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            val = val * 10 + int'(cur[4*i +: 4]);
            mx  = mx * 10 + 9;
        end
        cy = 1'b0; er = 1'b0; nv = val;
        if (s.r || s.c) begin
            nv = 0;
        end else if (s.l) begin
            ok = 1'b1;
            for (int i = 0; i < nd; i++)
                if (s.v[4*i +: 4] > 4'd9) ok = 1'b0;
            if (ok) begin
                nv = 0;
                for (int i = nd - 1; i >= 0; i--)
                    nv = nv * 10 + int'(s.v[4*i +: 4]);
            end else begin
                er = 1'b1;
            end
        end else if (s.e) begin
            if (s.u) begin
                if (val == mx) begin
                    if (wr) begin nv = 0; cy = 1'b1; end
                end else nv = val + 1;
            end else begin
                if (val == 0) begin
                    if (wr) begin nv = mx; cy = 1'b1; end
                end else nv = val - 1;
            end
        end
        o = '0; tmp = nv;
        for (int i = 0; i < nd; i++) begin
            o[4*i +: 4] = 4'(tmp % 10);
            tmp = tmp / 10;
        end
        return {o, cy, er, nv == mx, nv == 0};
    endfunction

    task automatic drive(input stim_t s);
        logic [59:0] ex;
        logic [19:0] res;
        int nd;
        rst = s.r; clr = s.c; load = s.l; lv = s.v; en = s.e; up = s.u;
        for (int d = 0; d < 3; d++) begin
            nd  = (d == 0) ? 4 : ((d == 1) ? 2 : 1);
            res = mstep(nd, d != 1, mcnt[d], s);
            mcnt[d] = res[19:4];
            ex[d*20 +: 20] = res;
        end
        sb.push_back(ex);
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [59:0] ex;
        s.push_back(st(1, 0, 1, 16'h5555, 1, 1));
        s.push_back(st(1, 0, 1, 16'h1234, 1, 0));
        s.push_back(st(0, 0, 0, 16'h0000, 0, 0));
        foreach (s[i]) begin
            drive(s[i]); @(posedge clk); #1;
            ex = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d*20 +: 20] !== ex[d*20 +: 20]) begin
                    bad++;
                    $display("FAIL reset step%0d dut%0d got=%h want=%h",
                             i, d, act[d*20 +: 20], ex[d*20 +: 20]);
                end
            end
        end
    endtask

    task automatic test_up_chain();
        stim_t s[$];
        logic [59:0] ex;
        s.push_back(st(0, 0, 1, 16'h0998, 0, 0));
        s.push_back(st(0, 0, 0, 16'h0000, 1, 1));
        s.push_back(st(0, 0, 0, 16'h0000, 1, 1));
        s.push_back(st(0, 0, 0, 16'h0000, 0, 0));
        foreach (s[i]) begin
            drive(s[i]); @(posedge clk); #1;
            ex = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d*20 +: 20] !== ex[d*20 +: 20]) begin
                    bad++;
                    $display("FAIL up_chain step%0d dut%0d got=%h want=%h",
                             i, d, act[d*20 +: 20], ex[d*20 +: 20]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[$];
        logic [59:0] ex;
        s.push_back(st(0, 0, 1, 16'h9999, 0, 0));
        s.push_back(st(0, 0, 0, 16'h0000, 1, 1));
        s.push_back(st(0, 0, 0, 16'h0000, 0, 1));
        s.push_back(st(0, 0, 0, 16'h0000, 1, 0));
        s.push_back(st(0, 0, 0, 16'h0000, 0, 0));
        foreach (s[i]) begin
            drive(s[i]); @(posedge clk); #1;
            ex = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d*20 +: 20] !== ex[d*20 +: 20]) begin
                    bad++;
                    $display("FAIL wrap step%0d dut%0d got=%h want=%h",
                             i, d, act[d*20 +: 20], ex[d*20 +: 20]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        stim_t s[$];
        logic [59:0] ex;
        s.push_back(st(0, 1, 0, 16'h0000, 0, 0));
        s.push_back(st(0, 0, 1, 16'h0099, 0, 0));
        for (int i = 0; i < 5; i++) s.push_back(st(0, 0, 0, 16'h0, 1, 1));
        s.push_back(st(0, 1, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 3; i++) s.push_back(st(0, 0, 0, 16'h0, 1, 0));
        foreach (s[i]) begin
            drive(s[i]); @(posedge clk); #1;
            ex = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d*20 +: 20] !== ex[d*20 +: 20]) begin
                    bad++;
                    $display("FAIL saturate step%0d dut%0d got=%h want=%h",
                             i, d, act[d*20 +: 20], ex[d*20 +: 20]);
                end
            end
        end
    endtask

    task automatic test_load_err();
        stim_t s[$];
        logic [59:0] ex;
        s.push_back(st(0, 0, 1, 16'h0042, 0, 0));
        s.push_back(st(0, 0, 1, 16'h12A4, 1, 1));
        s.push_back(st(0, 0, 0, 16'h0000, 0, 0));
        s.push_back(st(0, 0, 1, 16'h1234, 1, 1));
        s.push_back(st(0, 0, 1, 16'hF0F0, 0, 0));
        s.push_back(st(0, 1, 1, 16'hAAAA, 1, 1));
        foreach (s[i]) begin
            drive(s[i]); @(posedge clk); #1;
            ex = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d*20 +: 20] !== ex[d*20 +: 20]) begin
                    bad++;
                    $display("FAIL load_err step%0d dut%0d got=%h want=%h",
                             i, d, act[d*20 +: 20], ex[d*20 +: 20]);
                end
            end
        end
    endtask

    task automatic test_clear_reset();
        stim_t s[$];
        logic [59:0] ex;
        s.push_back(st(0, 1, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 57; i++) s.push_back(st(0, 0, 0, 16'h0, 1, 1));
        s.push_back(st(0, 1, 0, 16'h0000, 1, 1));
        for (int i = 0; i < 12; i++) s.push_back(st(0, 0, 0, 16'h0, 1, 1));
        s.push_back(st(1, 0, 1, 16'h7777, 1, 1));
        s.push_back(st(0, 0, 0, 16'h0000, 0, 0));
        foreach (s[i]) begin
            drive(s[i]); @(posedge clk); #1;
            ex = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d*20 +: 20] !== ex[d*20 +: 20]) begin
                    bad++;
                    $display("FAIL clear_reset step%0d dut%0d got=%h want=%h",
                             i, d, act[d*20 +: 20], ex[d*20 +: 20]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        logic [59:0] ex;
        s.push_back(st(0, 1, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 22; i++) s.push_back(st(0, 0, 0, 16'h0, 1, 1));
        for (int i = 0; i < 4; i++)
            s.push_back(st(0, 0, 0, 16'h0, 0, i[0]));
        for (int i = 0; i < 23; i++) s.push_back(st(0, 0, 0, 16'h0, 1, 0));
        for (int i = 0; i < 6; i++)
            s.push_back(st(0, 0, 0, 16'h0, 1, i[0]));
        s.push_back(st(0, 0, 1, 16'h0001, 0, 0));
        for (int i = 0; i < 3; i++) s.push_back(st(0, 0, 0, 16'h0, 1, 0));
        foreach (s[i]) begin
            drive(s[i]); @(posedge clk); #1;
            ex = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (act[d*20 +: 20] !== ex[d*20 +: 20]) begin
                    bad++;
                    $display("FAIL back_to_back step%0d dut%0d got=%h want=%h",
                             i, d, act[d*20 +: 20], ex[d*20 +: 20]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) mcnt[d] = '0;
        @(posedge clk); #1;
        test_reset();
        test_up_chain();
        test_wrap();
        test_saturate();
        test_load_err();
        test_clear_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
